fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the pipelined TSC core. It sits directly upstream of decode and the hazard control unit, and consumes that unit's `pc_write`, `ir_write`, `stall_IFID` and `flush_IFID` outputs. It owns the PC, the instruction-memory request handshake and next-PC prediction. When the optional branch target buffer is compiled in, prediction uses it.

## Interface
- `WORD_SIZE`, 16, instruction and address width.
- `BTB_IDX_W`, 4, BTB index bits; the BTB has 2^BTB_IDX_W entries.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  reset, asynchronous and active-high.
- `pc_write`  in  1  from hazard unit; the PC may update.
- `ir_write`  in  1  from hazard unit; IF/ID may load.
- `stall_IFID`  in  1  from hazard unit; hold IF/ID.
- `flush_IFID`  in  1  from hazard unit; squash IF/ID and redirect.
- `redirect_pc`  in  WORD_SIZE  corrected PC, valid while `flush_IFID` is high.
- `i_mem_read`  out  1  instruction read request.
- `i_address`  out  WORD_SIZE  word address of the request.
- `i_data`  in  WORD_SIZE  returned instruction, valid with `i_mem_ready`.
- `i_mem_ready`  in  1  memory completes the current request this cycle.
- `upd_valid`  in  1  BTB update strobe, from resolved branch or jump.
- `upd_pc`, `upd_target`  in  WORD_SIZE  address of the resolved instruction and its target.
- `upd_taken`  in  1  resolved direction.
- `inst_IFID`, `pc_IFID`, `pred_pc_IFID`  out  WORD_SIZE  IF/ID instruction, its PC, and its predicted next PC.
- `valid_IFID`  out  1  IF/ID holds a real instruction.
- `fetch_busy`  out  1  a request is outstanding and not ready; feeds the global stall.

## Operation
- **State machine:** three states, ABORT, REQ and HOLD. The reset state is ABORT.
- **ABORT:** `i_mem_read`=0. Next state is REQ unconditionally. This state separates a dropped request from the new one.
- **REQ:**
  - `i_mem_read`=1 and `i_address`=PC. `i_address` is stable until `i_mem_ready` or a flush.
  - `i_mem_ready`=1 with `ir_write`=1 and `stall_IFID`=0: IF/ID loads {`i_data`, PC, next_pc} with valid=1. If `pc_write` is set, PC becomes next_pc. The state stays REQ, so the next request issues back-to-back.
  - `i_mem_ready`=1 while stalled: the instruction and its next_pc are captured into a hold buffer. Next state is HOLD.
  - `i_mem_ready`=0: the state stays REQ and `fetch_busy`=1.
- **HOLD:** `i_mem_read`=0. When `stall_IFID`=0 and `ir_write`=1, IF/ID loads from the hold buffer, PC updates (gated by `pc_write`), and the next state is REQ.
- **Flush:** `flush_IFID`=1 in any state does the following.
  - IF/ID gets valid=0 and `inst_IFID`=`INST_BUBBLE`.
  - PC becomes `redirect_pc` and the hold buffer is dropped.
  - If a request was outstanding (REQ), the next state is ABORT and any `i_mem_ready` in that cycle is ignored. Otherwise the next state is REQ.
- **Priority:** reset first, then `flush_IFID`, then `stall_IFID`, then normal advance. A flush and a stall in the same cycle resolves to the flush.
- **next_pc:** PC+1, a word increment that wraps modulo 2^WORD_SIZE (0xFFFF+1 gives 0x0000). The BTB overrides it when compiled in.

## Timing
- **Reset values:** PC=0; state ABORT; `i_mem_read`=0; `i_address`=0; `inst_IFID`=`INST_BUBBLE`; `pc_IFID`=0; `pred_pc_IFID`=0; `valid_IFID`=0; `fetch_busy`=0; all BTB valid bits=0.
- **First request:** `i_mem_read` rises in the first cycle after reset deasserts, at `i_address`=0.
- **Zero-wait memory:** `i_mem_ready` in the same cycle as the request gives one instruction per cycle. IF/ID updates at the edge where ready is sampled high.
- **N-wait memory:** IF/ID updates N cycles after the request. `fetch_busy` is high for exactly those N cycles.
- **Redirect penalty:** `flush_IFID` at edge t makes the corrected fetch visible on `i_address` at t+1 if no request was pending, or at t+2 through ABORT if one was.
- **Outputs:** `i_mem_read`, `i_address` and `fetch_busy` decode combinationally from the state and PC. All IF/ID outputs are registered.

## Configuration
- **`FETCH_BTB_EN` defined:** a direct-mapped BTB provides prediction.
  - Each entry holds a valid bit, tag PC[WORD_SIZE-1:BTB_IDX_W], target, and a 2-bit saturating counter.
  - next_pc is the target when the entry hits and its counter is at least 2; otherwise PC+1.
  - Update on `upd_valid`: a tag miss allocates the entry with counter 2 if taken or 1 if not taken. A tag hit writes the target and increments the counter if taken, decrements it if not, saturating at 3 and 0.
  - A lookup and an update to the same index in the same cycle returns the pre-update contents.
- **`FETCH_BTB_EN` undefined:** no BTB storage; next_pc is always PC+1, `pred_pc_IFID`=`pc_IFID`+1, and the `upd_*` ports are ignored.

## Structure
- **Shared package:** `INST_BUBBLE` (the NOP encoding from the opcode header), the fetch state enum (ABORT/REQ/HOLD), and the BTB entry typedef.
- **Sub-module:** `fetch_btb` holds the storage array, the hit/predict lookup and the counter update, and is instantiated only under `FETCH_BTB_EN`.

## Test plan
- **Reset then zero-wait memory, no stalls:** `i_address` goes 0,1,2,3 on consecutive cycles; `pc_IFID` follows one cycle behind with valid=1.
- **2-wait memory at PC=5:** `fetch_busy` is high for 2 cycles and `i_address` holds 5; IF/ID loads `i_data` with `pc_IFID`=5 on the third edge.
- **`stall_IFID`=1 with `pc_write`=`ir_write`=0 for 3 cycles while `i_mem_ready` returns at PC=8:** state is HOLD and `i_mem_read`=0; IF/ID loads PC 8 in the cycle after the stall releases, then `i_address`=9.
- **`flush_IFID` with `redirect_pc`=0x0040 during an outstanding request:** the next IF/ID is a bubble with valid=0; `i_mem_read` is low for one cycle, then `i_address`=0x0040.
- **PC=0xFFFF:** the next request is at 0x0000.
- **`FETCH_BTB_EN` branch:** update pc=0x10, target=0x30, taken, twice, then fetch 0x10; `pred_pc_IFID`=0x30 and the next `i_address`=0x30. One not-taken update drops the counter to 2 and prediction stays 0x30; a second drops it to 1 and prediction becomes 0x11.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared definitions for the TSC fetch stage. These are the
//               bubble encoding, the fetch state enum, and the BTB entry
//               metadata with its counter update helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    // NOP encoding inserted into IF/ID when it is squashed
    localparam logic [15:0] INST_BUBBLE = 16'hF01C;

    typedef enum logic [1:0] {
        ST_ABORT = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    // Per-entry BTB metadata. Tag and target live in parallel arrays so
    // their widths can follow the module parameters.
    typedef struct packed {
        logic       valid;
        logic [1:0] ctr;
    } btb_entry_t;

    // Two-bit saturating counter step
    function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken && (ctr != 2'd3))
            res = ctr + 2'd1;
        else if (!taken && (ctr != 2'd0))
            res = ctr - 2'd1;
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_btb.sv
`default_nettype none
// ============================================================================
// Module      : fetch_btb
// Description : Direct-mapped branch target buffer with 2-bit counters.
//               Lookup is combinational on the current PC. Updates land at
//               the clock edge, so a same-cycle lookup sees the old contents.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_btb
    import fetch_stage_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int BTB_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] lookup_pc,
    output logic [WORD_SIZE-1:0] pred_pc,
    input  logic                 upd_valid,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic [WORD_SIZE-1:0] upd_target,
    input  logic                 upd_taken
);
    localparam int DEPTH = 1 << BTB_IDX_W;
    localparam int TAG_W = WORD_SIZE - BTB_IDX_W;
    localparam logic [WORD_SIZE-1:0] C_ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

    btb_entry_t           r_meta   [DEPTH];
    logic [TAG_W-1:0]     r_tag    [DEPTH];
    logic [WORD_SIZE-1:0] r_target [DEPTH];

    logic [BTB_IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0]     w_lk_tag;
    logic                 w_lk_taken;
    logic [BTB_IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0]     w_up_tag;
    logic                 w_up_hit;

    assign w_lk_idx   = lookup_pc[BTB_IDX_W-1:0];
    assign w_lk_tag   = lookup_pc[WORD_SIZE-1:BTB_IDX_W];
    assign w_lk_taken = r_meta[w_lk_idx].valid && (r_tag[w_lk_idx] == w_lk_tag)
                        && r_meta[w_lk_idx].ctr[1];
    assign pred_pc    = w_lk_taken ? r_target[w_lk_idx] : (lookup_pc + C_ONE);

    assign w_up_idx = upd_pc[BTB_IDX_W-1:0];
    assign w_up_tag = upd_pc[WORD_SIZE-1:BTB_IDX_W];
    assign w_up_hit = r_meta[w_up_idx].valid && (r_tag[w_up_idx] == w_up_tag);

    // Valid bits and counters: allocate on miss, saturate on hit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                r_meta[i] <= '0;
        end else if (upd_valid) begin
            r_meta[w_up_idx].valid <= 1'b1;
            if (w_up_hit)
                r_meta[w_up_idx].ctr <= sat_ctr(r_meta[w_up_idx].ctr, upd_taken);
            else
                r_meta[w_up_idx].ctr <= upd_taken ? 2'd2 : 2'd1;
        end
    end

    // Tag and target storage; only meaningful behind a set valid bit
    always_ff @(posedge clk) begin
        if (upd_valid) begin
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= upd_target;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : TSC instruction fetch. It holds the PC, runs the instruction
//               memory handshake and next-PC prediction, and drives the IF/ID
//               pipeline register. Defining FETCH_BTB_EN compiles in the
//               branch target buffer (fetch_btb).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int BTB_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pc_write,
    input  logic                 ir_write,
    input  logic                 stall_IFID,
    input  logic                 flush_IFID,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic                 i_mem_read,
    output logic [WORD_SIZE-1:0] i_address,
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic                 i_mem_ready,
    input  logic                 upd_valid,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic [WORD_SIZE-1:0] upd_target,
    input  logic                 upd_taken,
    output logic [WORD_SIZE-1:0] inst_IFID,
    output logic [WORD_SIZE-1:0] pc_IFID,
    output logic [WORD_SIZE-1:0] pred_pc_IFID,
    output logic                 valid_IFID,
    output logic                 fetch_busy
);
    localparam logic [WORD_SIZE-1:0] C_BUBBLE = WORD_SIZE'(INST_BUBBLE);

    fetch_state_t         r_state;
    fetch_state_t         w_state_nxt;
    logic [WORD_SIZE-1:0] r_pc;
    logic [WORD_SIZE-1:0] r_hold_inst;
    logic [WORD_SIZE-1:0] r_hold_next;
    logic [WORD_SIZE-1:0] w_next_pc;
    logic                 w_load_mem;
    logic                 w_load_hold;
    logic                 w_capture;
    logic                 w_advance;

`ifdef FETCH_BTB_EN
    fetch_btb #(
        .WORD_SIZE (WORD_SIZE),
        .BTB_IDX_W (BTB_IDX_W)
    ) u_btb (
        .clk        (clk),
        .reset      (reset),
        .lookup_pc  (r_pc),
        .pred_pc    (w_next_pc),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .upd_taken  (upd_taken)
    );
`else
    localparam logic [WORD_SIZE-1:0] C_ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};
    localparam int c_unused_btb_idx_w = BTB_IDX_W;
    logic w_unused_upd;
    assign w_unused_upd = ^{upd_valid, upd_pc, upd_target, upd_taken};
    assign w_next_pc    = r_pc + C_ONE;
`endif

    assign i_address = r_pc;
    assign w_advance = ir_write && !stall_IFID;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_ABORT;
        else
            r_state <= w_state_nxt;
    end

    // Next state, memory request outputs and IF/ID load selects
    always_comb begin
        w_state_nxt = r_state;
        i_mem_read  = 1'b0;
        fetch_busy  = 1'b0;
        w_load_mem  = 1'b0;
        w_load_hold = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_ABORT: begin
                w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                i_mem_read = 1'b1;
                fetch_busy = !i_mem_ready;
                if (flush_IFID) begin
                    w_state_nxt = ST_ABORT;
                end else if (i_mem_ready) begin
                    if (w_advance) begin
                        w_load_mem = 1'b1;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (flush_IFID) begin
                    w_state_nxt = ST_REQ;
                end else if (w_advance) begin
                    w_load_hold = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_ABORT;
            end
        endcase
    end

    // PC and hold buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc        <= '0;
            r_hold_inst <= '0;
            r_hold_next <= '0;
        end else begin
            if (flush_IFID)
                r_pc <= redirect_pc;
            else if (w_load_mem && pc_write)
                r_pc <= w_next_pc;
            else if (w_load_hold && pc_write)
                r_pc <= r_hold_next;
            if (w_capture) begin
                r_hold_inst <= i_data;
                r_hold_next <= w_next_pc;
            end
        end
    end

    // IF/ID pipeline register; holds when nothing new is delivered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_IFID    <= C_BUBBLE;
            pc_IFID      <= '0;
            pred_pc_IFID <= '0;
            valid_IFID   <= 1'b0;
        end else if (flush_IFID) begin
            inst_IFID  <= C_BUBBLE;
            valid_IFID <= 1'b0;
        end else if (w_load_mem) begin
            inst_IFID    <= i_data;
            pc_IFID      <= r_pc;
            pred_pc_IFID <= w_next_pc;
            valid_IFID   <= 1'b1;
        end else if (w_load_hold) begin
            inst_IFID    <= r_hold_inst;
            pc_IFID      <= r_pc;
            pred_pc_IFID <= r_hold_next;
            valid_IFID   <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. Directed scenarios are
//               followed by randomized traffic, all compared against a
//               behavioural fetch model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
    localparam logic [15:0] C_BUBBLE = 16'hF01C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pc_write, ir_write, stall_IFID, flush_IFID, i_mem_ready;
    logic        upd_valid, upd_taken;
    logic [15:0] redirect_pc, i_data, upd_pc, upd_target;
    logic        i_mem_read, valid_IFID, fetch_busy;
    logic [15:0] i_address, inst_IFID, pc_IFID, pred_pc_IFID;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a request is outstanding, an instruction is parked, or neither
    // (the dead cycle after a dropped request)
    bit          m_req, m_held, m_valid;
    logic [15:0] m_pc, m_held_inst, m_held_next, m_inst, m_ifpc, m_pred;
`ifdef FETCH_BTB_EN
    bit          b_val [16];
    logic [11:0] b_tag [16];
    logic [15:0] b_tgt [16];
    int          b_ctr [16];
`endif

    fetch_stage #(.WORD_SIZE(16), .BTB_IDX_W(4)) dut (
        .clk(clk), .reset(reset), .pc_write(pc_write), .ir_write(ir_write),
        .stall_IFID(stall_IFID), .flush_IFID(flush_IFID), .redirect_pc(redirect_pc),
        .i_mem_read(i_mem_read), .i_address(i_address), .i_data(i_data),
        .i_mem_ready(i_mem_ready), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_taken(upd_taken), .inst_IFID(inst_IFID),
        .pc_IFID(pc_IFID), .pred_pc_IFID(pred_pc_IFID), .valid_IFID(valid_IFID),
        .fetch_busy(fetch_busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] predict(input logic [15:0] pc);
`ifdef FETCH_BTB_EN
        int idx = int'(pc % 16);
        if (b_val[idx] && b_tag[idx] == pc[15:4] && b_ctr[idx] >= 2)
            return b_tgt[idx];
`endif
        return pc + 16'd1;
    endfunction

    task automatic model_edge();
        logic [15:0] nx;
        bit          adv;
        nx  = predict(m_pc);
        adv = ir_write && !stall_IFID;
        if (flush_IFID) begin
            m_valid = 0; m_inst = C_BUBBLE; m_pc = redirect_pc; m_held = 0;
            m_req   = m_req ? 1'b0 : 1'b1;
        end else if (m_req) begin
            if (i_mem_ready) begin
                if (adv) begin
                    m_inst = i_data; m_ifpc = m_pc; m_pred = nx; m_valid = 1;
                    if (pc_write) m_pc = nx;
                end else begin
                    m_held = 1; m_held_inst = i_data; m_held_next = nx; m_req = 0;
                end
            end
        end else if (m_held) begin
            if (adv) begin
                m_inst = m_held_inst; m_ifpc = m_pc; m_pred = m_held_next; m_valid = 1;
                if (pc_write) m_pc = m_held_next;
                m_held = 0; m_req = 1;
            end
        end else begin
            m_req = 1;
        end
`ifdef FETCH_BTB_EN
        if (upd_valid) begin
            int idx = int'(upd_pc % 16);
            if (b_val[idx] && b_tag[idx] == upd_pc[15:4])
                b_ctr[idx] = upd_taken ? ((b_ctr[idx] == 3) ? 3 : b_ctr[idx] + 1)
                                       : ((b_ctr[idx] == 0) ? 0 : b_ctr[idx] - 1);
            else
                b_ctr[idx] = upd_taken ? 2 : 1;
            b_val[idx] = 1; b_tag[idx] = upd_pc[15:4]; b_tgt[idx] = upd_target;
        end
`endif
    endtask

    // One clock: check request outputs, advance the model, check IF/ID
    task automatic step(input string tag);
        #2;
        check_eq({tag, ":rd"},   i_mem_read, m_req);
        check_eq({tag, ":addr"}, i_address,  m_pc);
        check_eq({tag, ":busy"}, fetch_busy, m_req && !i_mem_ready);
        model_edge();
        @(posedge clk); #1;
        check_eq({tag, ":inst"},  inst_IFID,    m_inst);
        check_eq({tag, ":pc"},    pc_IFID,      m_ifpc);
        check_eq({tag, ":pred"},  pred_pc_IFID, m_pred);
        check_eq({tag, ":valid"}, valid_IFID,   m_valid);
    endtask

    task automatic drive(input bit rdy, input bit pw, input bit iw, input bit st,
                         input bit fl, input logic [15:0] redir);
        i_mem_ready = rdy; pc_write = pw; ir_write = iw; stall_IFID = st;
        flush_IFID = fl; redirect_pc = redir; i_data = 16'($urandom);
    endtask

`ifdef FETCH_BTB_EN
    // Redirect to addr and complete one zero-wait fetch there
    task automatic fetch_at(input logic [15:0] addr);
        drive(0, 1, 1, 0, 1, addr); step("btb_flush");
        drive(0, 1, 1, 0, 0, 0);    step("btb_gap");
        drive(1, 1, 1, 0, 0, 0);    step("btb_fetch");
    endtask
`endif

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        upd_valid = 0; upd_taken = 0; upd_pc = 0; upd_target = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_rd",    i_mem_read,   0);
        check_eq("rst_addr",  i_address,    0);
        check_eq("rst_busy",  fetch_busy,   0);
        check_eq("rst_inst",  inst_IFID,    C_BUBBLE);
        check_eq("rst_pc",    pc_IFID,      0);
        check_eq("rst_pred",  pred_pc_IFID, 0);
        check_eq("rst_valid", valid_IFID,   0);
        reset = 0;
        m_req = 0; m_held = 0; m_pc = 0; m_inst = C_BUBBLE; m_ifpc = 0; m_pred = 0;
        m_valid = 0; m_held_inst = 0; m_held_next = 0;
`ifdef FETCH_BTB_EN
        for (int i = 0; i < 16; i++) begin
            b_val[i] = 0; b_tag[i] = 0; b_tgt[i] = 0; b_ctr[i] = 0;
        end
`endif

        // Zero-wait memory, no stalls
        drive(1, 1, 1, 0, 0, 0);
        step("first");
        check_eq("first_rd", i_mem_read, 1);
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 1, 0, 0, 0);
            step("zw");
            check_eq("zw_pc_IFID", pc_IFID, k);
            check_eq("zw_valid", valid_IFID, 1);
            check_eq("zw_next_addr", i_address, k + 1);
        end

        // Two-wait memory at PC 5
        for (int k = 0; k < 2; k++) begin
            drive(0, 1, 1, 0, 0, 0);
            #1;
            check_eq("w2_busy", fetch_busy, 1);
            check_eq("w2_addr", i_address, 16'd5);
            step("w2");
        end
        drive(1, 1, 1, 0, 0, 0);
        begin
            logic [15:0] d5;
            d5 = i_data;
            step("w2_done");
            check_eq("w2_pc_IFID", pc_IFID, 16'd5);
            check_eq("w2_inst", inst_IFID, d5);
        end
        for (int k = 0; k < 2; k++) begin
            drive(1, 1, 1, 0, 0, 0);
            step("zw67");
        end

        // Stall while the fetch at PC 8 completes
        drive(1, 0, 0, 1, 0, 0); step("stall_cap");
        for (int k = 0; k < 2; k++) begin
            check_eq("hold_rd", i_mem_read, 0);
            drive(0, 0, 0, 1, 0, 0); step("stall");
        end
        drive(0, 1, 1, 0, 0, 0); step("release");
        check_eq("release_pc_IFID", pc_IFID, 16'd8);
        check_eq("release_addr", i_address, 16'd9);
        check_eq("release_rd", i_mem_read, 1);

        // Flush during an outstanding request
        drive(0, 1, 1, 0, 1, 16'h0040); step("flush");
        check_eq("flush_valid", valid_IFID, 0);
        check_eq("flush_inst", inst_IFID, C_BUBBLE);
        check_eq("flush_gap_rd", i_mem_read, 0);
        drive(0, 1, 1, 0, 0, 0); step("flush_gap");
        check_eq("redir_addr", i_address, 16'h0040);
        check_eq("redir_rd", i_mem_read, 1);

        // PC wrap from 0xFFFF
        drive(0, 1, 1, 0, 1, 16'hFFFF); step("wrap_flush");
        drive(0, 1, 1, 0, 0, 0);        step("wrap_gap");
        drive(1, 1, 1, 0, 0, 0);        step("wrap_fetch");
        check_eq("wrap_pc_IFID", pc_IFID, 16'hFFFF);
        check_eq("wrap_addr", i_address, 16'h0000);

`ifdef FETCH_BTB_EN
        // Train a taken branch at 0x10, then weaken it
        upd_valid = 1; upd_pc = 16'h0010; upd_target = 16'h0030; upd_taken = 1;
        drive(0, 1, 1, 0, 0, 0); step("btb_upd1");
        step("btb_upd2");
        upd_valid = 0;
        fetch_at(16'h0010);
        check_eq("btb_pred_taken", pred_pc_IFID, 16'h0030);
        check_eq("btb_next_addr", i_address, 16'h0030);
        upd_valid = 1; upd_taken = 0;
        drive(0, 1, 1, 0, 0, 0); step("btb_nt1");
        upd_valid = 0;
        fetch_at(16'h0010);
        check_eq("btb_pred_ctr2", pred_pc_IFID, 16'h0030);
        upd_valid = 1; upd_taken = 0;
        drive(0, 1, 1, 0, 0, 0); step("btb_nt2");
        upd_valid = 0;
        fetch_at(16'h0010);
        check_eq("btb_pred_ctr1", pred_pc_IFID, 16'h0011);
`endif

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            bit st, pw, iw;
            st = ($urandom % 5) == 0;
            pw = !st; iw = !st;
            if (($urandom % 8) == 0) begin
                pw = 1'($urandom); iw = 1'($urandom);
            end
            drive(($urandom % 3) != 0, pw, iw, st, ($urandom % 17) == 0, 16'($urandom));
            upd_valid  = ($urandom % 4) == 0;
            upd_pc     = 16'($urandom % 64);
            upd_target = 16'($urandom);
            upd_taken  = 1'($urandom);
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a run that never reaches its summary
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
